// File: rtl/prediction_residual_if.sv
// Bus bundle for the JPEG-LS prediction-residual stage.
// The master side presents one sample and its prediction context per cycle.
// The slave side returns the registered, modulo-reduced residual.
interface prediction_residual_if #(
  parameter int pixel_length    = 8,
  parameter int C_length        = 8,
  parameter int mode_length     = 2,
  parameter int residual_length = 9
);
  logic                       in_valid;
  logic [pixel_length-1:0]    x_prediction;
  logic [pixel_length-1:0]    x;
  logic                       sign;
  logic [C_length-1:0]        C;
  logic [mode_length-1:0]     mode;
  logic                       RIType;
  logic                       a_b_compare;
  logic                       out_valid;
  logic [residual_length-1:0] x_residual;

  modport master (
    output in_valid, x_prediction, x, sign, C, mode, RIType, a_b_compare,
    input  out_valid, x_residual
  );

  modport slave (
    input  in_valid, x_prediction, x, sign, C, mode, RIType, a_b_compare,
    output out_valid, x_residual
  );
endinterface

// File: rtl/prediction_residual.sv
// JPEG-LS prediction-error stage for lossless coding (NEAR=0).
// Regular mode: bias-correct the prediction with C, clamp to [0, MAXVAL],
// subtract from the sample and apply the context sign. Run-interruption mode:
// subtract and apply the RIType / Ra>Rb sign rule. Run and reserved modes
// yield zero. Every result is reduced modulo RANGE into [-RANGE/2, RANGE/2-1].
// Optional macro PREDRES_PIPE2_EN adds a register after the clamp, giving
// two cycles of latency instead of one.
module prediction_residual #(
  parameter int pixel_length    = 8,
  parameter int C_length        = 8,
  parameter int mode_length     = 2,
  parameter int residual_length = 9
) (
  input logic                  clk,
  input logic                  reset,
  prediction_residual_if.slave bus
);

  // Correction width: covers Px +/- C for the most negative C without overflow.
  localparam int CW = ((pixel_length > C_length) ? pixel_length : C_length) + 2;
  // Error width: x - Pc spans [-MAXVAL, MAXVAL], and RANGE must be representable.
  localparam int EW = pixel_length + 2;

  localparam logic [mode_length-1:0] MODE_REGULAR = mode_length'(0);
  localparam logic [mode_length-1:0] MODE_RI      = mode_length'(2);

  localparam logic signed [EW-1:0] RANGE_W = {2'b01, {pixel_length{1'b0}}};
  localparam logic signed [EW-1:0] HALF_W  = {3'b001, {(pixel_length-1){1'b0}}};

  // Everything the subtract/reduce half needs, optionally registered.
  typedef struct packed {
    logic                    valid;
    logic                    active;  // regular or run-interruption
    logic                    neg;     // negate the raw error
    logic [pixel_length-1:0] x;
    logic [pixel_length-1:0] pred;    // clamped Pc, or Ra/Rb in run interruption
  } stage_t;

  stage_t s1_d;
  stage_t sb;

  logic signed [CW-1:0]    px_ext;
  logic signed [CW-1:0]    c_ext;
  logic signed [CW-1:0]    pc_sum;
  logic [pixel_length-1:0] pc_clamped;

  logic signed [EW-1:0]       e_diff;
  logic signed [EW-1:0]       e_sgn;
  logic signed [EW-1:0]       e_mod;
  logic signed [pixel_length:0] e_short;

  logic                       out_valid_d, out_valid_q;
  logic [residual_length-1:0] x_residual_d, x_residual_q;

  // Bias correction, clamp and sign-rule selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    s1_d       = '0;
    px_ext     = signed'({{(CW-pixel_length){1'b0}}, bus.x_prediction});
    c_ext      = signed'({{(CW-C_length){bus.C[C_length-1]}}, bus.C});
    pc_sum     = bus.sign ? (px_ext - c_ext) : (px_ext + c_ext);
    pc_clamped = pc_sum[pixel_length-1:0];
    if (pc_sum[CW-1]) begin
      pc_clamped = '0;
    end else if (|pc_sum[CW-2:pixel_length]) begin
      pc_clamped = '1;
    end

    s1_d.valid  = bus.in_valid;
    s1_d.active = (bus.mode == MODE_REGULAR) || (bus.mode == MODE_RI);
    s1_d.x      = bus.x;
    if (bus.mode == MODE_RI) begin
      s1_d.neg  = !bus.RIType && bus.a_b_compare;
      s1_d.pred = bus.x_prediction;
    end else begin
      s1_d.neg  = bus.sign;
      s1_d.pred = pc_clamped;
    end
  end

`ifdef PREDRES_PIPE2_EN
  stage_t s1_q;

  // Post-clamp pipeline register; reset clears its valid along with the payload.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // Subtract/reduce half consumes the registered stage.
  always_comb begin
    sb = s1_q;
  end
`else
  // Subtract/reduce half consumes the same-cycle correction result.
  always_comb begin
    sb = s1_d;
  end
`endif

  // Subtract, apply sign, reduce modulo RANGE, and choose the next output.
  always_comb begin
    e_diff = signed'({2'b00, sb.x}) - signed'({2'b00, sb.pred});
    e_sgn  = sb.neg ? -e_diff : e_diff;
    if (!sb.active) begin
      e_sgn = '0;
    end

    e_mod = e_sgn;
    if (e_mod[EW-1]) begin
      e_mod = e_mod + RANGE_W;
    end
    if (e_mod >= HALF_W) begin
      e_mod = e_mod - RANGE_W;
    end
    e_short = e_mod[pixel_length:0];

    out_valid_d  = sb.valid;
    x_residual_d = sb.valid ? residual_length'(e_short) : x_residual_q;
  end

  // Output register; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      x_residual_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      x_residual_q <= x_residual_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.x_residual = x_residual_q;

endmodule

// File: tb/tb_prediction_residual.sv
// Directed, table-driven bench for prediction_residual (default single-stage build).
module tb_prediction_residual;

  logic clk;
  logic reset;

  prediction_residual_if #(
    .pixel_length(8), .C_length(8), .mode_length(2), .residual_length(9)
  ) bus ();

  prediction_residual #(
    .pixel_length(8), .C_length(8), .mode_length(2), .residual_length(9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic       sign;
    logic [7:0] c;
    logic [7:0] px;
    logic [7:0] x;
    logic       ritype;
    logic       abc;
    logic [8:0] exp_res;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid     = valid;
    bus.mode         = v.mode;
    bus.sign         = v.sign;
    bus.C            = v.c;
    bus.x_prediction = v.px;
    bus.x            = v.x;
    bus.RIType       = v.ritype;
    bus.a_b_compare  = v.abc;
  endtask

  logic [8:0] held;

  initial begin
    //            name           mode  sgn  C      Px     x      RIT  abc  expected
    vecs[0]  = '{"reg_pos",     2'b00, 1'b0, 8'd5,   8'd100, 8'd110, 1'b0, 1'b0, 9'd5};
    vecs[1]  = '{"reg_neg",     2'b00, 1'b1, 8'hFD,  8'd100, 8'd90,  1'b0, 1'b0, 9'd13};
    vecs[2]  = '{"clamp_hi",    2'b00, 1'b0, 8'd10,  8'd250, 8'd0,   1'b0, 1'b0, 9'd1};
    vecs[3]  = '{"wrap_200",    2'b00, 1'b0, 8'd0,   8'd0,   8'd200, 1'b0, 1'b0, 9'h1C8};
    vecs[4]  = '{"ri_neg",      2'b10, 1'b0, 8'd0,   8'd50,  8'd60,  1'b0, 1'b1, 9'h1F6};
    vecs[5]  = '{"ri_abc0",     2'b10, 1'b0, 8'd0,   8'd50,  8'd60,  1'b0, 1'b0, 9'd10};
    vecs[6]  = '{"ri_type1",    2'b10, 1'b0, 8'd0,   8'd50,  8'd60,  1'b1, 1'b1, 9'd10};
    vecs[7]  = '{"run_zero",    2'b01, 1'b1, 8'h55,  8'd17,  8'd230, 1'b0, 1'b1, 9'd0};
    vecs[8]  = '{"rsvd_zero",   2'b11, 1'b0, 8'd9,   8'd3,   8'd99,  1'b1, 1'b0, 9'd0};
    // C=-128 with sign=1: Pc=200+128=328 -> 255; E=10-255=-245 -> 245 -> 245-256=-11
    vecs[9]  = '{"cmin_hi",     2'b00, 1'b1, 8'h80,  8'd200, 8'd10,  1'b0, 1'b0, 9'h1F5};
    // C=-128 with sign=0: Pc=100-128=-28 -> 0; E=50
    vecs[10] = '{"cmin_lo",     2'b00, 1'b0, 8'h80,  8'd100, 8'd50,  1'b0, 1'b0, 9'd50};
    vecs[11] = '{"half_edge",   2'b00, 1'b0, 8'd0,   8'd0,   8'd128, 1'b0, 1'b0, 9'h180};
    vecs[12] = '{"half_m1",     2'b00, 1'b0, 8'd0,   8'd0,   8'd127, 1'b0, 1'b0, 9'h07F};
    // Run interruption ignores C and sign: E=255 -> -1
    vecs[13] = '{"ri_ignore_c", 2'b10, 1'b1, 8'd77,  8'd0,   8'd255, 1'b1, 1'b0, 9'h1FF};

    reset = 1'b1;
    drive(vecs[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_res",   32'(bus.x_residual), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    drive(vecs[0], 1'b0);
    @(posedge clk);
    #1;
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back table application, one result per cycle.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
      #2;
      if (i == 0) check("pre_edge_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check(vecs[i].name, 32'(bus.x_residual), 32'(vecs[i].exp_res));
    end

    // in_valid low: output holds, valid drops, even with new data on the bus.
    @(negedge clk);
    held = vecs[13].exp_res;
    drive(vecs[0], 1'b0);
    @(posedge clk);
    #1;
    check("hold_valid", 32'(bus.out_valid), 32'd0);
    check("hold_res",   32'(bus.x_residual), 32'(held));
    @(posedge clk);
    #1;
    check("hold2_res",  32'(bus.x_residual), 32'(held));

    // Reset with a result present and in_valid still high: reset wins.
    @(negedge clk);
    drive(vecs[1], 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_res",   32'(bus.x_residual), 32'd13);
    @(negedge clk);
    reset = 1'b1;
    drive(vecs[2], 1'b1);
    @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res",   32'(bus.x_residual), 32'd0);

    // Recovery after reset release.
    @(negedge clk);
    reset = 1'b0;
    drive(vecs[4], 1'b1);
    @(posedge clk);
    #1;
    check("recover_valid", 32'(bus.out_valid), 32'd1);
    check("recover_res",   32'(bus.x_residual), 32'h1F6);

    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
